// File: rtl/regfile_wb_queue_if.sv
// Writeback queue bus: request side, register-file write port side and
// hazard-lookup side of regfile_wb_queue bundled in one interface.
// master = writeback stage / decode / RF-facing environment, slave = queue.
interface regfile_wb_queue_if #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 16
);
   logic                       in_valid;
   logic                       in_ready;
   logic [AW-1:0]              in_dst;
   logic [DW-1:0]              in_data;
   logic                       flush;
   logic                       wr_grant;
   logic [AW-1:0]              W;
   logic [DW-1:0]              Data_in;
   logic                       W_en;
   logic [AW-1:0]              rd1_addr;
   logic [AW-1:0]              rd2_addr;
   logic                       busy1;
   logic                       busy2;
   logic [DW-1:0]              fwd1_data;
   logic [DW-1:0]              fwd2_data;
   logic [$clog2(DEPTH):0]     count;

   modport master (
      output in_valid, in_dst, in_data, flush, wr_grant, rd1_addr, rd2_addr,
      input  in_ready, W, Data_in, W_en, busy1, busy2, fwd1_data, fwd2_data, count
   );

   modport slave (
      input  in_valid, in_dst, in_data, flush, wr_grant, rd1_addr, rd2_addr,
      output in_ready, W, Data_in, W_en, busy1, busy2, fwd1_data, fwd2_data, count
   );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback FIFO in front of the 32 x 16 register file write port.
// Drains one entry per granted cycle and reports pending writes per read
// address so decode can stall. Optional macro WBQ_FORWARD_EN adds the
// youngest-match forwarding path; without it fwd1_data/fwd2_data are 0.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 16
) (
   input  logic               clk,
   input  logic               rst,
   regfile_wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]    dst_q  [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [PW-1:0]    wp_q, wp_d;
   logic [PW-1:0]    rp_q, rp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             push, pop, ready, nonempty;
   logic [DEPTH-1:0] slot_vld;

   assign nonempty = (cnt_q != '0);
   // A full queue refuses even when the head is leaving this cycle.
   assign ready    = (cnt_q < CW'(DEPTH)) && !bus.flush;
   assign push     = bus.in_valid && ready;
   // Reset also suppresses the write so nothing reaches the RF while clearing.
   assign pop      = nonempty && bus.wr_grant && !bus.flush && !rst;

   assign bus.in_ready = ready;
   assign bus.W_en     = pop;
   assign bus.W        = nonempty ? dst_q[rp_q]  : '0;
   assign bus.Data_in  = nonempty ? data_q[rp_q] : '0;
   assign bus.count    = cnt_q;

   // Slot occupancy: a slot is live when its distance from the head is below count.
   always_comb begin
      logic [PW-1:0] off;
      off      = '0;
      slot_vld = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off         = PW'(i) - rp_q;
         slot_vld[i] = ({1'b0, off} < cnt_q);
      end
   end

   // Pending-write lookup for both read ports; the head counts until it commits.
   always_comb begin
      bus.busy1 = 1'b0;
      bus.busy2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (slot_vld[i] && (dst_q[i] == bus.rd1_addr)) bus.busy1 = 1'b1;
         if (slot_vld[i] && (dst_q[i] == bus.rd2_addr)) bus.busy2 = 1'b1;
      end
   end

`ifdef WBQ_FORWARD_EN
   // Walk head-to-tail so the youngest matching entry wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx           = '0;
      bus.fwd1_data = '0;
      bus.fwd2_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rp_q + PW'(k);
         if ((CW'(k) < cnt_q) && (dst_q[idx] == bus.rd1_addr)) bus.fwd1_data = data_q[idx];
         if ((CW'(k) < cnt_q) && (dst_q[idx] == bus.rd2_addr)) bus.fwd2_data = data_q[idx];
      end
   end
`else
   assign bus.fwd1_data = '0;
   assign bus.fwd2_data = '0;
`endif

   // Pointer and occupancy next state; flush empties the queue.
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (bus.flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) wp_d = wp_q + PW'(1);
         if (pop)  rp_d = rp_q + PW'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Control state register; reset wins over flush and every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents need no reset since occupancy gates every use.
   always_ff @(posedge clk) begin
      if (push) begin
         dst_q[wp_q]  <= bus.in_dst;
         data_q[wp_q] <= bus.in_data;
      end
   end
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios followed by random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_regfile_wb_queue;
   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 16;
`ifdef WBQ_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic [AW-1:0] dst;
      logic [DW-1:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   regfile_wb_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

   regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   ent_t          mq[$];
   logic [DW-1:0] rf_m [32];
   logic [DW-1:0] rf_d [32];
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] d, input logic [DW-1:0] x,
                        input logic g, input logic f);
      bus.in_valid = v;
      bus.in_dst   = d;
      bus.in_data  = x;
      bus.wr_grant = g;
      bus.flush    = f;
   endtask

   // One clock: compare every output with the model, then advance both.
   task automatic cycle();
      logic          e_rdy, e_wen, e_push, e_b1, e_b2;
      logic [AW-1:0] e_w;
      logic [DW-1:0] e_d, e_f1, e_f2;
      logic          d_wen;
      logic [AW-1:0] d_w;
      logic [DW-1:0] d_data;
      ent_t          inc;
      #1;
      e_rdy  = (mq.size() < DEPTH) && !bus.flush;
      e_push = bus.in_valid && e_rdy;
      e_wen  = (mq.size() != 0) && bus.wr_grant && !bus.flush && !rst;
      e_w    = (mq.size() != 0) ? mq[0].dst  : '0;
      e_d    = (mq.size() != 0) ? mq[0].data : '0;
      e_b1 = 1'b0; e_b2 = 1'b0; e_f1 = '0; e_f2 = '0;
      foreach (mq[i]) begin
         if (mq[i].dst == bus.rd1_addr) begin e_b1 = 1'b1; if (FWD) e_f1 = mq[i].data; end
         if (mq[i].dst == bus.rd2_addr) begin e_b2 = 1'b1; if (FWD) e_f2 = mq[i].data; end
      end
      chk("count",    32'(bus.count),     32'(mq.size()));
      chk("in_ready", 32'(bus.in_ready),  32'(e_rdy));
      chk("W_en",     32'(bus.W_en),      32'(e_wen));
      chk("W",        32'(bus.W),         32'(e_w));
      chk("Data_in",  32'(bus.Data_in),   32'(e_d));
      chk("busy1",    32'(bus.busy1),     32'(e_b1));
      chk("busy2",    32'(bus.busy2),     32'(e_b2));
      chk("fwd1",     32'(bus.fwd1_data), 32'(e_f1));
      chk("fwd2",     32'(bus.fwd2_data), 32'(e_f2));
      chk("rf_rd1",   32'(rf_d[bus.rd1_addr]), 32'(rf_m[bus.rd1_addr]));
      d_wen  = bus.W_en;
      d_w    = bus.W;
      d_data = bus.Data_in;
      inc    = '{dst: bus.in_dst, data: bus.in_data};
      @(posedge clk);
      if (d_wen === 1'b1) rf_d[d_w] = d_data;
      if (rst || bus.flush) begin
         mq.delete();
      end else begin
         if (e_wen) begin
            rf_m[mq[0].dst] = mq[0].data;
            void'(mq.pop_front());
         end
         if (e_push) mq.push_back(inc);
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin rf_m[i] = '0; rf_d[i] = '0; end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      bus.rd1_addr = '0;
      bus.rd2_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state, then a single granted write to r1.
      cycle();
      drive(1'b1, 5'd1, 16'h4001, 1'b1, 1'b0);
      cycle();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t1_W_en", 32'(bus.W_en), 32'd1);
      chk("t1_W",    32'(bus.W), 32'd1);
      cycle();
      bus.rd1_addr = 5'd1;
      chk("t1_rf",   32'(rf_d[1]), 32'h4001);
      cycle();

      // Fill with grant held low, fifth push refused, then drain in order.
      for (int d = 2; d <= 6; d++) begin
         drive(1'b1, AW'(d), DW'(16'h2000 + d), 1'b0, 1'b0);
         cycle();
      end
      chk("t2_full", 32'(bus.count), 32'd4);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      repeat (5) cycle();
      chk("t2_r5", 32'(rf_d[5]), 32'h2005);
      chk("t2_r6", 32'(rf_d[6]), 32'h0);

      // Two writes to r7: busy and youngest forwarding, then drain.
      bus.rd1_addr = 5'd7;
      drive(1'b1, 5'd7, 16'h1111, 1'b0, 1'b0); cycle();
      drive(1'b1, 5'd7, 16'h2222, 1'b0, 1'b0); cycle();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      chk("t3_busy", 32'(bus.busy1), 32'd1);
      chk("t3_fwd",  32'(bus.fwd1_data), FWD ? 32'h2222 : 32'h0);
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      repeat (3) cycle();
      chk("t3_rf7",  32'(rf_d[7]), 32'h2222);

      // Full queue streaming: one push and one pop per cycle, pointers wrap.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, AW'(8 + (i % 6)), DW'(16'h3000 + i), (i >= 4), 1'b0);
         cycle();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      repeat (5) cycle();

      // Flush with three queued and a push offered in the same cycle.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, AW'(20 + i), DW'(16'h5000 + i), 1'b0, 1'b0);
         cycle();
      end
      bus.rd2_addr = 5'd21;
      drive(1'b1, 5'd23, 16'h5555, 1'b1, 1'b1);
      chk("t5_wen", 32'(bus.W_en), 32'd0);
      cycle();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t5_cnt", 32'(bus.count), 32'd0);
      cycle();

      // Reset mid-drain with two entries.
      drive(1'b1, 5'd24, 16'h6000, 1'b0, 1'b0); cycle();
      drive(1'b1, 5'd25, 16'h6001, 1'b0, 1'b0); cycle();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("t6_wen", 32'(bus.W_en), 32'd0);
      chk("t6_cnt", 32'(bus.count), 32'd0);
      cycle();

      // Random traffic on a narrow register range to force address matches.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), DW'($urandom),
               ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
         bus.rd1_addr = AW'($urandom_range(0, 7));
         bus.rd2_addr = AW'($urandom_range(0, 7));
         rst = ($urandom_range(0, 49) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
